vram_port_arbiter: RTL and testbench

Round-robin arbiter that shares one single-port byte-write write-first VRAM among NUM_REQ requesters, e.g. host bus interface, layer fetch and sprite fetch. It sits directly in front of the RAM instance. It grants at most one access per clock, drives the RAM address, data and byte-enables, and tracks in-flight reads so each read's data is returned only to the requester that issued it, after the RAM's fixed read latency.

---
 rtl/vram_port_arbiter.sv | 117 +++++++++++
 tb/tb_vram_port_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vram_port_arbiter
// Brief    : Round-robin arbiter sharing one byte-write VRAM port, with read tags
// Revision : 1.0
// ============================================================================
module vram_port_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int ADDR_W     = 15,
  parameter int NB_COL     = 4,
  parameter int COL_WIDTH  = 8,
  parameter int RD_LATENCY = 2
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [NUM_REQ-1:0]                    req_i,
  input  logic [NUM_REQ*NB_COL-1:0]             we_i,
  input  logic [NUM_REQ*ADDR_W-1:0]             addr_i,
  input  logic [NUM_REQ*NB_COL*COL_WIDTH-1:0]   wdata_i,
  output logic [NUM_REQ-1:0]                    ack_o,
  output logic [NUM_REQ-1:0]                    rvalid_o,
  output logic [NB_COL*COL_WIDTH-1:0]           rdata_o,
  output logic [ADDR_W-1:0]                     ram_addr_o,
  output logic [NB_COL*COL_WIDTH-1:0]           ram_din_o,
  output logic [NB_COL-1:0]                     ram_we_o,
  input  logic [NB_COL*COL_WIDTH-1:0]           ram_dout_i
);

  localparam int DW    = NB_COL * COL_WIDTH;
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [IDX_W:0]   c_num_req = (IDX_W+1)'(NUM_REQ);
  localparam logic [IDX_W-1:0] c_last    = IDX_W'(NUM_REQ - 1);

  logic [IDX_W-1:0]  r_ptr;
  logic [IDX_W-1:0]  w_gnt_idx;
  logic [IDX_W-1:0]  w_ptr_nxt;
  logic [IDX_W:0]    w_cand;
  logic              w_gnt_vld;
  logic              w_gnt_ok;
  logic              w_rd_push;
  logic [NB_COL-1:0] w_sel_we;

  logic [ADDR_W-1:0] w_addr_arr [NUM_REQ];
  logic [DW-1:0]     w_din_arr  [NUM_REQ];
  logic [NB_COL-1:0] w_we_arr   [NUM_REQ];

  logic [RD_LATENCY-1:0] r_pipe_vld;
  logic [IDX_W-1:0]      r_pipe_idx [RD_LATENCY];

  // Search upward from ptr, wrapping; the first asserted request wins.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    w_cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_cand = {1'b0, r_ptr} + (IDX_W+1)'(k);
      if (w_cand >= c_num_req) begin
        w_cand = w_cand - c_num_req;
      end
      if (!w_gnt_vld && req_i[w_cand[IDX_W-1:0]]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = w_cand[IDX_W-1:0];
      end
    end
  end

  // Grants are masked while reset is held so the RAM never sees a write.
  assign w_gnt_ok  = w_gnt_vld & rst_n;
  assign w_ptr_nxt = (w_gnt_idx == c_last) ? '0 : w_gnt_idx + 1'b1;
  assign w_sel_we  = w_we_arr[w_gnt_idx];
  assign w_rd_push = w_gnt_ok && (w_sel_we == '0);

  // With no grant w_gnt_idx is 0, so requester 0's fields drive the RAM.
  assign ram_addr_o = w_addr_arr[w_gnt_idx];
  assign ram_din_o  = w_din_arr[w_gnt_idx];
  assign ram_we_o   = w_gnt_ok ? w_sel_we : '0;
  assign rdata_o    = ram_dout_i;

  generate
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
      assign w_addr_arr[i] = addr_i[i*ADDR_W +: ADDR_W];
      assign w_din_arr[i]  = wdata_i[i*DW +: DW];
      assign w_we_arr[i]   = we_i[i*NB_COL +: NB_COL];
      assign ack_o[i]      = w_gnt_ok && (w_gnt_idx == IDX_W'(i));
      assign rvalid_o[i]   = r_pipe_vld[RD_LATENCY-1] &&
                             (r_pipe_idx[RD_LATENCY-1] == IDX_W'(i));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (w_gnt_vld) begin
      r_ptr <= w_ptr_nxt;
    end
  end

  // Read tag pipe: aligned with the RAM read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pipe_vld <= '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        r_pipe_idx[i] <= '0;
      end
    end else begin
      r_pipe_vld[0] <= w_rd_push;
      r_pipe_idx[0] <= w_gnt_idx;
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_pipe_vld[i] <= r_pipe_vld[i-1];
        r_pipe_idx[i] <= r_pipe_idx[i-1];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_vram_port_arbiter
// Brief    : Directed bench for vram_port_arbiter at read latencies 2 and 1
// Revision : 1.0
// ============================================================================
module tb_vram_port_arbiter;

  localparam int NR  = 3;
  localparam int AW  = 15;
  localparam int NBC = 4;
  localparam int CW  = 8;
  localparam int DW  = NBC * CW;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [NR-1:0]     req;
  logic [NR*NBC-1:0] we;
  logic [NR*AW-1:0]  addr;
  logic [NR*DW-1:0]  wdata;

  logic [NR-1:0]  ack2, rv2, ack1, rv1;
  logic [DW-1:0]  rdata2, rdin2, rdout2, rdata1, rdin1, rdout1;
  logic [AW-1:0]  raddr2, raddr1;
  logic [NBC-1:0] rwe2, rwe1;

  int checks   = 0;
  int failures = 0;

  vram_port_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .NB_COL(NBC), .COL_WIDTH(CW), .RD_LATENCY(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
    .ack_o(ack2), .rvalid_o(rv2), .rdata_o(rdata2), .ram_addr_o(raddr2),
    .ram_din_o(rdin2), .ram_we_o(rwe2), .ram_dout_i(rdout2)
  );

  vram_port_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .NB_COL(NBC), .COL_WIDTH(CW), .RD_LATENCY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
    .ack_o(ack1), .rvalid_o(rv1), .rdata_o(rdata1), .ram_addr_o(raddr1),
    .ram_din_o(rdin1), .ram_we_o(rwe1), .ram_dout_i(rdout1)
  );

  // Write-first byte-write RAM models.
  logic [DW-1:0] mem2 [0:(1<<AW)-1];
  logic [DW-1:0] mem1 [0:(1<<AW)-1];
  logic [DW-1:0] st2;

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] din,
                                          input logic [NBC-1:0] be);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < NBC; b++) if (be[b]) r[b*CW +: CW] = din[b*CW +: CW];
    return r;
  endfunction

  always @(posedge clk) begin
    mem2[raddr2] <= merge(mem2[raddr2], rdin2, rwe2);
    st2          <= merge(mem2[raddr2], rdin2, rwe2);
    rdout2       <= st2;
  end

  always @(posedge clk) begin
    mem1[raddr1] <= merge(mem1[raddr1], rdin1, rwe1);
    rdout1       <= merge(mem1[raddr1], rdin1, rwe1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic setr(input int i, input logic r, input logic [NBC-1:0] w,
                      input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[i]             = r;
    we[i*NBC +: NBC]   = w;
    addr[i*AW +: AW]   = a;
    wdata[i*DW +: DW]  = d;
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] e;

  initial begin
    req = '0; we = '0; addr = '0; wdata = '0; rst_n = 1'b0;
    for (int a = 0; a < 128; a++) begin
      mem2[a] = 32'h0; mem1[a] = 32'h0;
    end
    mem2[15'h10] = 32'hDEADBEEF; mem1[15'h10] = 32'hDEADBEEF;
    mem2[15'h05] = 32'hAABBCCDD; mem1[15'h05] = 32'hAABBCCDD;
    mem2[15'h20] = 32'hA; mem1[15'h20] = 32'hA;
    mem2[15'h21] = 32'hB; mem1[15'h21] = 32'hB;
    mem2[15'h22] = 32'hC; mem1[15'h22] = 32'hC;
    mem2[15'h30] = 32'h12345678; mem1[15'h30] = 32'h12345678;

    // Reset state, including requests asserted during reset
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack", 32'(ack2), 0);
    chk("rst_rvalid", 32'(rv2), 0);
    chk("rst_ram_we", 32'(rwe2), 0);
    setr(0, 1'b1, 4'hF, 15'h7, 32'h99);
    setr(2, 1'b1, 4'h3, 15'h8, 32'h77);
    #1;
    chk("rst_req_ack", 32'(ack2), 0);
    chk("rst_req_we", 32'(rwe2), 0);
    req = '0; we = '0;

    // Contention: all three reading 0x20+i; acks rotate, returns pipeline
    next_cyc();
    rst_n = 1'b1;
    for (int i = 0; i < NR; i++) setr(i, 1'b1, 4'h0, 15'(32'h20 + i), 32'h0);
    for (int k = 0; k < 9; k++) begin
      if (k > 0) next_cyc();
      if (k == 6) req = '0;
      #1;
      e = (k < 6) ? (32'd1 << (k % 3)) : 32'd0;
      chk("rr_ack_l2", 32'(ack2), e);
      chk("rr_ack_l1", 32'(ack1), e);
      if (k >= 2 && k < 8) begin
        chk("pipe_rv_l2", 32'(rv2), 32'd1 << ((k-2) % 3));
        chk("pipe_rd_l2", rdata2, 32'hA + 32'((k-2) % 3));
      end else begin
        chk("pipe_rv_l2_idle", 32'(rv2), 0);
      end
      if (k >= 1 && k < 7) begin
        chk("pipe_rv_l1", 32'(rv1), 32'd1 << ((k-1) % 3));
        chk("pipe_rd_l1", rdata1, 32'hA + 32'((k-1) % 3));
      end else begin
        chk("pipe_rv_l1_idle", 32'(rv1), 0);
      end
    end

    // Only requesters 0 and 2, both writing: alternate, never rvalid
    next_cyc();
    setr(0, 1'b1, 4'hF, 15'h40, 32'h40404040);
    setr(2, 1'b1, 4'hF, 15'h42, 32'h42424242);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) next_cyc();
      #1;
      chk("alt_ack", 32'(ack2), (k % 2 == 0) ? 32'd1 : 32'd4);
      chk("alt_addr", 32'(raddr2), (k % 2 == 0) ? 32'h40 : 32'h42);
      chk("alt_we", 32'(rwe2), 32'hF);
      chk("alt_no_rv", 32'(rv2), 0);
    end
    next_cyc();
    req = '0; we = '0;
    #1;
    chk("alt_end_ack", 32'(ack2), 0);
    chk("alt_end_we", 32'(rwe2), 0);

    // Single read by requester 1
    next_cyc();
    setr(1, 1'b1, 4'h0, 15'h10, 32'h0);
    #1;
    chk("sr_ack", 32'(ack2), 32'b010);
    chk("sr_addr", 32'(raddr2), 32'h10);
    chk("sr_rv0", 32'(rv2), 0);
    next_cyc();
    req = '0;
    #1;
    chk("sr_rv1", 32'(rv2), 0);
    next_cyc(); #1;
    chk("sr_rv2", 32'(rv2), 32'b010);
    chk("sr_data", rdata2, 32'hDEADBEEF);
    next_cyc(); #1;
    chk("sr_rv3", 32'(rv2), 0);

    // Byte write then read back by requester 0
    next_cyc();
    setr(0, 1'b1, 4'b0101, 15'h5, 32'h11223344);
    #1;
    chk("bw_ack", 32'(ack2), 32'b001);
    chk("bw_we", 32'(rwe2), 32'b0101);
    chk("bw_din", rdin2, 32'h11223344);
    next_cyc();
    setr(0, 1'b1, 4'h0, 15'h5, 32'h0);
    #1;
    chk("br_ack", 32'(ack2), 32'b001);
    chk("br_we", 32'(rwe2), 0);
    next_cyc();
    req = '0;
    #1;
    chk("bw_no_rv", 32'(rv2), 0);
    next_cyc(); #1;
    chk("br_rv", 32'(rv2), 32'b001);
    chk("br_data", rdata2, 32'hAA22CC44);

    // Reset mid-flight: ptr is 1 here, so requester 0 is found after wrapping
    next_cyc();
    setr(0, 1'b1, 4'h0, 15'h20, 32'h0);
    #1;
    chk("mf_ack", 32'(ack2), 32'b001);
    next_cyc();
    rst_n = 1'b0;
    setr(1, 1'b1, 4'h0, 15'h21, 32'h0);
    setr(2, 1'b1, 4'hF, 15'h30, 32'hFFFFFFFF);
    #1;
    chk("mf_rst_ack", 32'(ack2), 0);
    chk("mf_rst_we", 32'(rwe2), 0);
    chk("mf_rst_rv_l2", 32'(rv2), 0);
    chk("mf_rst_rv_l1", 32'(rv1), 0);
    next_cyc(); #1;
    chk("mf_rst_ack2", 32'(ack2), 0);
    next_cyc();
    rst_n = 1'b1;
    req = '0; we = '0;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) next_cyc();
      #1;
      chk("mf_no_rv_l2", 32'(rv2), 0);
      chk("mf_no_rv_l1", 32'(rv1), 0);
    end
    next_cyc();
    for (int i = 0; i < NR; i++) setr(i, 1'b1, 4'h0, 15'(32'h20 + i), 32'h0);
    #1;
    chk("post_rst_ptr", 32'(ack2), 32'b001);
    next_cyc();
    req = '0;

    // Idle
    for (int k = 0; k < 10; k++) begin
      next_cyc(); #1;
      chk("idle_ack", 32'(ack2), 0);
      chk("idle_we", 32'(rwe2), 0);
    end
    chk("idle_mem30", mem2[15'h30], 32'h12345678);
    chk("idle_mem10", mem2[15'h10], 32'hDEADBEEF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
